// File: rtl/sram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_ctrl
// Purpose  : Request/response front end for a single-port synchronous SRAM
//            (registered dout, dout forced to zero when not reading). A bus
//            master issues reads and writes on a valid/ready request channel.
//            Read data comes back on a valid/ready response channel. Every
//            SRAM pin is driven from a flop.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW        address width, SRAM depth is 2**AW
//   DW        data width
//   INIT_VAL  fill value written by the optional power-up init sequence
// Ports
//   clk, rst                 clock (posedge) and synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we/req_addr/req_wdata request payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                read data, stable while rsp_valid is high
//   mem_en/mem_we/mem_addr/mem_din  registered SRAM controls
//   mem_dout                 SRAM read data
//   init_done                controller initialised and serving requests
// Optional feature
//   SRAM_REQ_CTRL_INIT_EN    when defined, reset fills the whole SRAM with
//                            INIT_VAL (2**AW cycles) before any request is
//                            accepted. When not defined, init_done is tied to 1.
// ============================================================================
module sram_req_ctrl #(
  parameter int            AW       = 5,
  parameter int            DW       = 8,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  // request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  // response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  // SRAM side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  // status
  output logic          init_done
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,  // accepting requests; writes retire here
    ST_RD_ISSUE = 3'd1,  // SRAM samples the read at the end of this cycle
    ST_RD_CAPT  = 3'd2,  // mem_dout carries the read data
    ST_RSP      = 3'd3,  // response held until the master takes it
    ST_INIT     = 3'd4   // power-up fill (optional feature only)
  } state_t;

`ifdef SRAM_REQ_CTRL_INIT_EN
  localparam state_t        c_rst_state = ST_INIT;
  localparam logic [AW-1:0] c_cnt_last  = '1;
`else
  localparam state_t        c_rst_state = ST_IDLE;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t        state_q,     state_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_din_q,   mem_din_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef SRAM_REQ_CTRL_INIT_EN
  logic [AW-1:0] init_cnt_q,  init_cnt_d;
  logic          init_done_q, init_done_d;
`else
  // The fill value only matters when the init sequence is built in.
  logic [DW-1:0] unused_init_val;
  assign unused_init_val = INIT_VAL;
`endif

  logic w_req_acc;

  // Requests are taken only in IDLE, so a read fully serialises the port.
  assign req_ready = (state_q == ST_IDLE);
  assign w_req_acc = req_valid && req_ready;

  // --------------------------------------------------------------------------
  // Next-state and register-input logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    // The SRAM is idle unless a state explicitly drives an access this cycle.
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef SRAM_REQ_CTRL_INIT_EN
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (w_req_acc) begin
          mem_en_d   = 1'b1;
          mem_addr_d = req_addr;
          if (req_we) begin
            // Writes complete when the SRAM samples them, so the controller
            // stays in IDLE and can take one write per cycle.
            mem_we_d  = 1'b1;
            mem_din_d = req_wdata;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_RD_ISSUE: begin
        state_d = ST_RD_CAPT;
      end

      ST_RD_CAPT: begin
        // mem_dout is non-zero only in the cycle after a read access. This is
        // the only state that samples it.
        rsp_rdata_d = mem_dout;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

`ifdef SRAM_REQ_CTRL_INIT_EN
      ST_INIT: begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = init_cnt_q;
        mem_din_d  = INIT_VAL;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == c_cnt_last) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. Reset overrides everything, including a read
  // in flight, whose response is dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_rst_state;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef SRAM_REQ_CTRL_INIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_req_ctrl
// Purpose  : Directed, self-checking bench for sram_req_ctrl. It connects the
//            controller to a behavioural 32x8 synchronous SRAM (registered
//            dout, zero when not reading). The bench drives inputs and samples
//            outputs on the falling clock edge.
// Revision : 1.0 - initial release
// Macro    : SRAM_REQ_CTRL_INIT_EN adds the power-up fill scenarios.
// ============================================================================
module tb_sram_req_ctrl;

  localparam int            AW      = 5;
  localparam int            DW      = 8;
  localparam logic [DW-1:0] C_FILL  = 8'hFF;
`ifdef SRAM_REQ_CTRL_INIT_EN
  localparam bit            C_INIT  = 1'b1;
`else
  localparam bit            C_INIT  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          init_done;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_req_ctrl #(
    .AW       (AW),
    .DW       (DW),
    .INIT_VAL (C_FILL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .init_done (init_done)
  );

  // Behavioural SRAM: writes land at the edge, reads return data registered
  // one edge later, dout is zero whenever no read was issued.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  initial for (int k = 0; k < (1<<AW); k++) sram[k] = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] <= mem_din;
    if (mem_en && !mem_we) mem_dout <= sram[mem_addr];
    else                   mem_dout <= '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Waits for init_done with a bounded budget and checks how many cycles it took.
  task automatic wait_init(input int exp_cycles, input string tag);
    int n = 0;
    while (!init_done && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_init_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("wr_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    chk("wr_issue", 32'({mem_en, mem_we, mem_addr, mem_din}), 32'({1'b1, 1'b1, a, d}));
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  // Read with optional response stall. When junk is set, a write request is
  // held on the request channel while the controller is busy. That write
  // must be ignored.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input int stall, input bit junk, input string tag);
    int lat = 0;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    rsp_ready = (stall == 0);
    step();
    chk({tag, "_issue"}, 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, a}));
    req_valid = junk; req_we = junk; req_addr = 5'd9; req_wdata = 8'h11;
    while (!rsp_valid && lat < 8) begin
      chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp));
    chk({tag, "_rsp_ready_lo"}, 32'(req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      chk({tag, "_hold"}, 32'({rsp_valid, rsp_rdata, req_ready, mem_en}),
          32'({1'b1, exp, 1'b0, 1'b0}));
    end
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0; req_we = 1'b0;
    chk({tag, "_done"}, 32'({rsp_valid, req_ready}), 32'({1'b0, 1'b1}));
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    step(); step();
    chk("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_din}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'(!C_INIT));
    chk("rst_init_done", 32'(init_done), 32'(!C_INIT));
    rst = 1'b0;

`ifdef SRAM_REQ_CTRL_INIT_EN
    // Ten init cycles in, the fill has reached address 9.
    repeat (10) step();
    chk("init_c10", 32'({mem_en, mem_we, mem_addr, mem_din, init_done, req_ready}),
        32'({1'b1, 1'b1, 5'd9, C_FILL, 1'b0, 1'b0}));
    rst = 1'b1;
    step();
    chk("init_rst", 32'({mem_en, mem_addr}), 32'd0);
    rst = 1'b0;
    step();
    chk("init_restart", 32'({mem_en, mem_we, mem_addr, mem_din}),
        32'({1'b1, 1'b1, 5'd0, C_FILL}));
    wait_init(31, "init");
    do_read(5'd0, C_FILL, 0, 1'b0, "rd_init0");
    do_read(5'd20, C_FILL, 0, 1'b0, "rd_init20");
`else
    wait_init(0, "noinit");
`endif

    // ---------------- burst of 10 writes ----------------
    for (int i = 0; i < 10; i++) begin
      chk("burst_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = 1'b1;
      req_addr = 5'(i); req_wdata = 8'(8'hA0 + i);
      step();
      chk("burst_mem", 32'({mem_en, mem_we, mem_addr, mem_din}),
          32'({1'b1, 1'b1, 5'(i), 8'(8'hA0 + i)}));
    end
    req_valid = 1'b0; req_we = 1'b0;
    step();
    chk("burst_end", 32'({mem_en, mem_we}), 32'd0);

    // ---------------- reads ----------------
    do_read(5'd3, 8'hA3, 0, 1'b0, "rd3");
    do_read(5'd7, 8'hA7, 5, 1'b1, "rd7_bp");
    do_read(5'd9, 8'hA9, 0, 1'b0, "rd9_nojunk");

    // ---------------- write-then-read hazard ----------------
    do_write(5'd31, 8'h5C);
    do_read(5'd31, 8'h5C, 0, 1'b0, "rd31_haz");

    // ---------------- reset in RD_CAPT ----------------
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
    step();                 // read accepted, now RD_ISSUE
    req_valid = 1'b0;
    step();                 // now RD_CAPT
    rsp_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("midrd_rst_mem", 32'({mem_en, mem_we, mem_addr}), 32'd0);
    chk("midrd_rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    chk("midrd_rst_ready", 32'(req_ready), 32'(!C_INIT));
    wait_init(C_INIT ? 32 : 0, "midrd");
    for (int s = 0; s < 4; s++) begin
      chk("midrd_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    rsp_ready = 1'b0;
    // Memory contents survive a controller reset unless init refills them.
    do_read(5'd3, C_INIT ? C_FILL : 8'hA3, 0, 1'b0, "rd3_after_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
